clipping_sequencer: RTL and testbench

CLIPPING_SEQUENCER -- requirements
Module: clipping_sequencer

---
 rtl/clipping_sequencer.sv | 149 ++++++++++++++
 tb/tb_clipping_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clipping_sequencer.sv
// rtl/clipping_sequencer.sv - object-list sequencer for the line clipping pipeline
//
// Walks a list of num_objs objects starting at base_addr. One object is fetched per
// four-cycle object period. A period is skipped, and counted in stall_cnt, when the
// line FIFO is almost full at the period boundary.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              list request (IDLE only) / synchronous cancel
//   base_addr, num_objs       list descriptor, latched on accepted start
//   f0_almost_full            line FIFO backpressure, sampled at period boundaries
//   cycle_1..cycle_4          one-hot phase strobes of the object period
//   obj_vld, prev_obj_vld     fetch in this period / fetch in the previous period
//   obj_addr                  object memory read address, stable per period
//   busy, done                list in progress / one-cycle completion pulse
//   stall_cnt                 saturating count of backpressure-skipped periods
module clipping_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  num_objs,
  input  logic               f0_almost_full,
  output logic               cycle_1,
  output logic               cycle_2,
  output logic               cycle_3,
  output logic               cycle_4,
  output logic               obj_vld,
  output logic               prev_obj_vld,
  output logic [ADDR_W-1:0]  obj_addr,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [1:0]         phase;
  logic [ADDR_W-1:0]  remaining, remaining_nxt;
  logic [ADDR_W-1:0]  obj_addr_nxt;
  logic [ADDR_W-1:0]  pending;
  logic               obj_vld_nxt, prev_obj_vld_nxt, done_nxt;
  logic [STALL_W-1:0] stall_cnt_nxt;
  logic               boundary;

  // The edge that ends a cycle_4 cycle closes the current object period.
  assign boundary = (phase == 2'd3);

  // Objects still to fetch once the fetch of the current period is accounted for.
  assign pending = obj_vld ? (remaining - ADDR_ONE) : remaining;

  assign cycle_1 = (phase == 2'd0);
  assign cycle_2 = (phase == 2'd1);
  assign cycle_3 = (phase == 2'd2);
  assign cycle_4 = (phase == 2'd3);
  assign busy    = (state != IDLE);

  // The phase counter free-runs in every state so period timing is never disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 2'd0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      obj_addr     <= '0;
      obj_vld      <= 1'b0;
      prev_obj_vld <= 1'b0;
      done         <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      obj_addr     <= obj_addr_nxt;
      obj_vld      <= obj_vld_nxt;
      prev_obj_vld <= prev_obj_vld_nxt;
      done         <= done_nxt;
      stall_cnt    <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    remaining_nxt    = remaining;
    obj_addr_nxt     = obj_addr;
    obj_vld_nxt      = obj_vld;
    prev_obj_vld_nxt = prev_obj_vld;
    done_nxt         = 1'b0;
    stall_cnt_nxt    = stall_cnt;

    case (state)
      IDLE: begin
        // abort has no effect of its own in IDLE, but still wins over a same-cycle start.
        if (start && !abort) begin
          if (num_objs != '0) begin
            state_nxt     = RUN;
            remaining_nxt = num_objs;
            obj_addr_nxt  = base_addr;
            stall_cnt_nxt = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      default: begin
        if (abort) begin
          state_nxt        = IDLE;
          obj_vld_nxt      = 1'b0;
          prev_obj_vld_nxt = 1'b0;
          remaining_nxt    = '0;
        end else if (boundary) begin
          prev_obj_vld_nxt = obj_vld;
          if (obj_vld) begin
            remaining_nxt = pending;
            obj_addr_nxt  = obj_addr + ADDR_ONE;
          end
          obj_vld_nxt = (state == RUN) && (pending != '0) && !f0_almost_full;
          if (state == RUN) begin
            // Leaving RUN on the boundary after the last fetch gives exactly one
            // split-only period (prev_obj_vld=1, obj_vld=0) in DRAIN.
            if (pending == '0) begin
              state_nxt = DRAIN;
            end else if (f0_almost_full && (stall_cnt != '1)) begin
              stall_cnt_nxt = stall_cnt + STALL_ONE;
            end
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_clipping_sequencer.sv
// tb/tb_clipping_sequencer.sv - self-checking bench for clipping_sequencer
module tb_clipping_sequencer;

  localparam int ADDR_W  = 10;
  localparam int STALL_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [ADDR_W-1:0]  base_addr;
  logic [ADDR_W-1:0]  num_objs;
  logic               f0_almost_full;
  logic               cycle_1, cycle_2, cycle_3, cycle_4;
  logic               obj_vld, prev_obj_vld;
  logic [ADDR_W-1:0]  obj_addr;
  logic               busy, done;
  logic [STALL_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Scoreboard of object addresses the DUT is expected to fetch, in order.
  logic [ADDR_W-1:0] exp_q[$];

  logic              mon_en    = 1'b0;
  logic              have_prev = 1'b0;
  logic              last_vld  = 1'b0;
  logic              per_vld   = 1'b0;
  logic              per_busy  = 1'b0;
  logic [ADDR_W-1:0] per_addr  = '0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] num;
    int                af_at;      // RUN boundary number (1-based) with almost_full=1, 0 = none
    bit                poke;       // pulse a second start (num_objs=7) while busy
    int                exp_stall;
    int                exp_bounds; // boundaries from acceptance up to the one before done
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  clipping_sequencer #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .num_objs       (num_objs),
    .f0_almost_full (f0_almost_full),
    .cycle_1        (cycle_1),
    .cycle_2        (cycle_2),
    .cycle_3        (cycle_3),
    .cycle_4        (cycle_4),
    .obj_vld        (obj_vld),
    .prev_obj_vld   (prev_obj_vld),
    .obj_addr       (obj_addr),
    .busy           (busy),
    .done           (done),
    .stall_cnt      (stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cycle"}, {28'd0, cycle_4, cycle_3, cycle_2, cycle_1}, 32'h1);
    check({tag, "_obj_vld"}, {31'd0, obj_vld}, 32'd0);
    check({tag, "_prev_obj_vld"}, {31'd0, prev_obj_vld}, 32'd0);
    check({tag, "_obj_addr"}, {22'd0, obj_addr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
  endtask

  // Period monitor: pops the scoreboard on every fetch period, checks that
  // prev_obj_vld lags obj_vld by one period and that outputs hold within a period.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (cycle_1) begin
        if (have_prev) check("prev_lag", {31'd0, prev_obj_vld}, {31'd0, last_vld});
        if (obj_vld) begin
          if (exp_q.size() == 0) begin
            check("extra_fetch", {22'd0, obj_addr}, 32'hFFFF_FFFF);
          end else begin
            check("fetch_addr", {22'd0, obj_addr}, {22'd0, exp_q.pop_front()});
          end
        end
        last_vld  = obj_vld;
        per_vld   = obj_vld;
        per_addr  = obj_addr;
        per_busy  = busy;
        have_prev = 1'b1;
      end else if (have_prev && per_busy) begin
        check("period_stable", {21'd0, obj_vld, obj_addr}, {21'd0, per_vld, per_addr});
      end
    end
  end

  task automatic run_list(input vec_t v, input int idx);
    int                bcount   = 0;
    bit                seen     = 1'b0;
    int                notbusy  = 0;
    logic [ADDR_W-1:0] a;
    a = v.base;
    for (int i = 0; i < int'(v.num); i++) begin
      exp_q.push_back(a);
      a = a + 10'd1;
    end
    have_prev = 1'b0;
    mon_en    = 1'b1;
    @(negedge clk);
    start     = 1'b1;
    base_addr = v.base;
    num_objs  = v.num;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 10'h2AA;
    num_objs  = 10'd9;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) notbusy++;
      start = (v.poke && c == 3);
      if (start) begin
        num_objs  = 10'd7;
        base_addr = 10'h3A0;
      end
      if (cycle_4) begin
        bcount++;
        f0_almost_full = (bcount == v.af_at);
      end else begin
        f0_almost_full = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    f0_almost_full = 1'b0;
    start          = 1'b0;
    check($sformatf("v%0d_done_seen", idx), {31'd0, seen}, 32'd1);
    check($sformatf("v%0d_bounds", idx), bcount, v.exp_bounds);
    check($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_busy_gap", idx), notbusy, 0);
    check($sformatf("v%0d_stall_cnt", idx), {16'd0, stall_cnt}, v.exp_stall);
    check($sformatf("v%0d_fetches_left", idx), exp_q.size(), 0);
    @(negedge clk);
    check($sformatf("v%0d_done_width", idx), {31'd0, done}, 32'd0);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int  cnt;
    bit  found;

    vecs[0] = '{10'h010, 10'd3, 0, 1'b0, 0, 5};
    vecs[1] = '{10'h010, 10'd3, 2, 1'b0, 1, 6};
    vecs[2] = '{10'h3FE, 10'd4, 0, 1'b0, 0, 6};
    vecs[3] = '{10'h100, 10'd1, 1, 1'b0, 1, 4};
    vecs[4] = '{10'h055, 10'd2, 3, 1'b0, 0, 4};
    vecs[5] = '{10'h030, 10'd2, 0, 1'b1, 0, 4};
    vecs[6] = '{10'h200, 10'd5, 5, 1'b0, 1, 8};

    rst            = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    f0_almost_full = 1'b0;
    base_addr      = '0;
    num_objs       = '0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_list(vecs[i], i);

    // Empty list: done next cycle, busy never rises.
    @(negedge clk);
    start = 1'b1; num_objs = 10'd0; base_addr = 10'h123;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("zero_done_width", {31'd0, done}, 32'd0);
    check("zero_busy_after", {31'd0, busy}, 32'd0);

    // abort together with start in IDLE keeps the sequencer idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_objs = 10'd3; base_addr = 10'h040;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);
    check("abort_start_done", {31'd0, done}, 32'd0);

    // abort in the second fetch period of a 5-object list.
    @(negedge clk);
    start = 1'b1; num_objs = 10'd5; base_addr = 10'h020;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (obj_vld && prev_obj_vld && cycle_2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reach_fetch2", {31'd0, found}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_obj_vld", {31'd0, obj_vld}, 32'd0);
    check("abort_prev_obj_vld", {31'd0, prev_obj_vld}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_phase", {28'd0, cycle_4, cycle_3, cycle_2, cycle_1}, 32'h4);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_quiet", cnt, 0);

    // Asynchronous reset mid-list at phase 2.
    @(negedge clk);
    start = 1'b1; num_objs = 10'd3; base_addr = 10'h050;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (obj_vld && busy && cycle_3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach_run", {31'd0, found}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    check_reset("mid_rst_held");
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("rst_quiet", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
